// File: rtl/axi_router_pkg.sv
// axi_router_pkg: shared types for the AXI write-channel routers.
package axi_router_pkg;

    localparam int AXI_LEN_BITS = 4;

    typedef enum logic [1:0] {
        DEST_S0   = 2'd0,
        DEST_S1   = 2'd1,
        DEST_SDEF = 2'd2
    } dest_e;

    typedef struct packed {
        dest_e                   dest;
        logic [AXI_LEN_BITS-1:0] len;
    } aw_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } state_e;

endpackage

// File: rtl/wdata_router_if.sv
// wdata_router_if: AW observation and W channel signals around the write-data router.
interface wdata_router_if #(
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = 4,
    parameter int LEN_BITS  = 4
);
    logic [LEN_BITS-1:0]  AWLEN_M;
    logic                 AWVALID_S0, AWREADY_S0;
    logic                 AWVALID_S1, AWREADY_S1;
    logic                 AWVALID_SDEFAULT, AWREADY_SDEFAULT;
    logic                 aw_full;
    logic [DATA_BITS-1:0] WDATA_M1;
    logic [STRB_BITS-1:0] WSTRB_M1;
    logic                 WLAST_M1, WVALID_M1, WREADY_M1;
    logic [DATA_BITS-1:0] WDATA_S0, WDATA_S1, WDATA_SDEFAULT;
    logic [STRB_BITS-1:0] WSTRB_S0, WSTRB_S1, WSTRB_SDEFAULT;
    logic                 WLAST_S0, WLAST_S1, WLAST_SDEFAULT;
    logic                 WVALID_S0, WVALID_S1, WVALID_SDEFAULT;
    logic                 WREADY_S0, WREADY_S1, WREADY_SDEFAULT;
    logic                 wlast_err;

    modport slave (
        input  AWLEN_M, AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1,
               AWVALID_SDEFAULT, AWREADY_SDEFAULT,
               WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
               WREADY_S0, WREADY_S1, WREADY_SDEFAULT,
        output aw_full, WREADY_M1,
               WDATA_S0, WDATA_S1, WDATA_SDEFAULT,
               WSTRB_S0, WSTRB_S1, WSTRB_SDEFAULT,
               WLAST_S0, WLAST_S1, WLAST_SDEFAULT,
               WVALID_S0, WVALID_S1, WVALID_SDEFAULT, wlast_err
    );

    modport master (
        output AWLEN_M, AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1,
               AWVALID_SDEFAULT, AWREADY_SDEFAULT,
               WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
               WREADY_S0, WREADY_S1, WREADY_SDEFAULT,
        input  aw_full, WREADY_M1,
               WDATA_S0, WDATA_S1, WDATA_SDEFAULT,
               WSTRB_S0, WSTRB_S1, WSTRB_SDEFAULT,
               WLAST_S0, WLAST_S1, WLAST_SDEFAULT,
               WVALID_S0, WVALID_S1, WVALID_SDEFAULT, wlast_err
    );

endinterface

// File: rtl/wdata_router_dest_fifo.sv
// dest_fifo: in-order queue of accepted write addresses (destination + burst length).
module dest_fifo
    import axi_router_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  aw_entry_t din,
    output aw_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      empty_next
);
    localparam int AW = $clog2(DEPTH);

    aw_entry_t     mem_q [DEPTH];
    aw_entry_t     mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full       = count_q == (AW+1)'(DEPTH);
        empty      = count_q == '0;
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        mem_d      = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = din;
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        empty_next = count_d == '0;
        head       = mem_q[rd_ptr_q];
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/wdata_router.sv
// wdata_router: steers M1 write beats to the slave that took the matching address
// and regenerates WLAST from the recorded burst length.
module wdata_router
    import axi_router_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int DATA_BITS = 32,
    parameter int STRB_BITS = 4,
    parameter int LEN_BITS  = 4
) (
    input logic          clk,
    input logic          rst,
    wdata_router_if.slave bus
);
    state_e              state_q, state_d;
    logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
    aw_entry_t           aw_entry, head;
    logic                aw_s0, aw_s1, aw_sd, aw_push;
    logic                fifo_full, fifo_empty, fifo_empty_next;
    logic                active, sel_ready, is_last, hs, pop;

    always_comb begin
        aw_s0         = bus.AWVALID_S0 && bus.AWREADY_S0;
        aw_s1         = bus.AWVALID_S1 && bus.AWREADY_S1;
        aw_sd         = bus.AWVALID_SDEFAULT && bus.AWREADY_SDEFAULT;
        aw_push       = aw_s0 || aw_s1 || aw_sd;
        aw_entry.dest = aw_s0 ? DEST_S0 : aw_s1 ? DEST_S1 : DEST_SDEF;
        aw_entry.len  = AXI_LEN_BITS'(bus.AWLEN_M);
    end

    dest_fifo #(.DEPTH(DEPTH)) u_dest_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (aw_push),
        .pop        (pop),
        .din        (aw_entry),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (fifo_empty_next)
    );

    always_comb begin
        active              = state_q == ST_DATA;
        sel_ready           = head.dest == DEST_S0 ? bus.WREADY_S0 :
                              head.dest == DEST_S1 ? bus.WREADY_S1 : bus.WREADY_SDEFAULT;
        is_last             = beat_cnt_q == LEN_BITS'(head.len);
        bus.WREADY_M1       = active && sel_ready;
        hs                  = bus.WVALID_M1 && bus.WREADY_M1;
        pop                 = hs && is_last;
        bus.WVALID_S0       = active && head.dest == DEST_S0 && bus.WVALID_M1;
        bus.WVALID_S1       = active && head.dest == DEST_S1 && bus.WVALID_M1;
        bus.WVALID_SDEFAULT = active && head.dest == DEST_SDEF && bus.WVALID_M1;
        bus.WLAST_S0        = active && head.dest == DEST_S0 && is_last;
        bus.WLAST_S1        = active && head.dest == DEST_S1 && is_last;
        bus.WLAST_SDEFAULT  = active && head.dest == DEST_SDEF && is_last;
        bus.wlast_err       = hs && (bus.WLAST_M1 != is_last);
        bus.aw_full         = fifo_full;
        beat_cnt_d          = pop ? '0 : hs ? beat_cnt_q + LEN_BITS'(1) : beat_cnt_q;
        // A push this cycle makes the entry usable next cycle, so enter DATA right away.
        state_d             = state_q == ST_IDLE ? ((aw_push || !fifo_empty) ? ST_DATA : ST_IDLE)
                                                 : ((pop && fifo_empty_next) ? ST_IDLE : ST_DATA);
    end

    assign bus.WDATA_S0       = DATA_BITS'(bus.WDATA_M1);
    assign bus.WDATA_S1       = DATA_BITS'(bus.WDATA_M1);
    assign bus.WDATA_SDEFAULT = DATA_BITS'(bus.WDATA_M1);
    assign bus.WSTRB_S0       = STRB_BITS'(bus.WSTRB_M1);
    assign bus.WSTRB_S1       = STRB_BITS'(bus.WSTRB_M1);
    assign bus.WSTRB_SDEFAULT = STRB_BITS'(bus.WSTRB_M1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_wdata_router.sv
// tb_wdata_router: directed scenarios checked against a queue-based model of the W router.
module tb_wdata_router;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wdata_router_if #(.DATA_BITS(32), .STRB_BITS(4), .LEN_BITS(4)) bus ();

    wdata_router #(.DEPTH(DEPTH), .DATA_BITS(32), .STRB_BITS(4), .LEN_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int dest;
        int len;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   bcnt = 0;
    bit   started = 0;
    int   rp[6] = '{1, 1, 0, 0, 1, 1};
    int   bp[6] = '{0, 1, 2, 2, 2, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return d == 0 ? bus.WREADY_S0 : d == 1 ? bus.WREADY_S1 : bus.WREADY_SDEFAULT;
    endfunction

    // Model: entries become visible at the edge they are accepted; one beat per handshake.
    always @(posedge clk) begin : model
        int  pd;
        bit  full_now;
        started = 1;
        if (!rst) begin
            q.delete();
            bcnt = 0;
        end else begin
            full_now = q.size() == DEPTH;
            pd = (bus.AWVALID_S0 && bus.AWREADY_S0) ? 0 :
                 (bus.AWVALID_S1 && bus.AWREADY_S1) ? 1 :
                 (bus.AWVALID_SDEFAULT && bus.AWREADY_SDEFAULT) ? 2 : -1;
            if (q.size() > 0 && bus.WVALID_M1 && rdy(q[0].dest)) begin
                if (bcnt == q[0].len) begin
                    q.delete(0);
                    bcnt = 0;
                end else bcnt++;
            end
            if (pd >= 0 && !full_now) q.push_back('{pd, int'(bus.AWLEN_M)});
        end
    end

    always @(negedge clk) begin : compare
        int d;
        bit last;
        if (started) begin
            d    = q.size() > 0 ? q[0].dest : -1;
            last = q.size() > 0 ? (bcnt == q[0].len) : 1'b0;
            check("wvalid", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT},
                  {d == 0 && bus.WVALID_M1, d == 1 && bus.WVALID_M1, d == 2 && bus.WVALID_M1});
            check("wlast", {bus.WLAST_S0, bus.WLAST_S1, bus.WLAST_SDEFAULT},
                  {d == 0 && last, d == 1 && last, d == 2 && last});
            check("wready_m1", bus.WREADY_M1, d >= 0 && rdy(d));
            check("aw_full", bus.aw_full, q.size() == DEPTH);
            check("wlast_err", bus.wlast_err,
                  d >= 0 && bus.WVALID_M1 && rdy(d) && (bus.WLAST_M1 != last));
            check("wdata_s0", bus.WDATA_S0, bus.WDATA_M1);
            check("wdata_s1", bus.WDATA_S1, bus.WDATA_M1);
            check("wdata_sd", bus.WDATA_SDEFAULT, bus.WDATA_M1);
            check("wstrb", {bus.WSTRB_S0, bus.WSTRB_S1, bus.WSTRB_SDEFAULT},
                  {3{bus.WSTRB_M1}});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input int k, input int len);
        bus.AWLEN_M          = 4'(len);
        bus.AWVALID_S0       = k == 0;
        bus.AWREADY_S0       = k == 0;
        bus.AWVALID_S1       = k == 1;
        bus.AWREADY_S1       = k == 1;
        bus.AWVALID_SDEFAULT = k == 2;
        bus.AWREADY_SDEFAULT = k == 2;
    endtask

    task automatic w(input logic [31:0] d, input logic [3:0] s, input logic last, input logic valid);
        bus.WDATA_M1  = d;
        bus.WSTRB_M1  = s;
        bus.WLAST_M1  = last;
        bus.WVALID_M1 = valid;
    endtask

    initial begin
        rst = 1'b0;
        aw(-1, 0);
        w(32'h0, 4'h0, 1'b0, 1'b0);
        bus.WREADY_S0 = 1'b1;
        bus.WREADY_S1 = 1'b1;
        bus.WREADY_SDEFAULT = 1'b1;
        tick;
        tick;
        @(negedge clk);
        check("rst_wready", bus.WREADY_M1, 1'b0);
        check("rst_full", bus.aw_full, 1'b0);
        check("rst_wvalid", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}, 3'b000);
        check("rst_wlast", {bus.WLAST_S0, bus.WLAST_S1, bus.WLAST_SDEFAULT}, 3'b000);
        check("rst_err", bus.wlast_err, 1'b0);
        tick;
        // single beat to S1
        rst = 1'b1;
        aw(1, 0);
        @(negedge clk);
        check("t1_idle_ready", bus.WREADY_M1, 1'b0);
        tick;
        aw(-1, 0);
        w(32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_wvalid_s1", bus.WVALID_S1, 1'b1);
        check("t1_wlast_s1", bus.WLAST_S1, 1'b1);
        check("t1_wdata_s1", bus.WDATA_S1, 32'hDEADBEEF);
        check("t1_wvalid_s0", bus.WVALID_S0, 1'b0);
        check("t1_err", bus.wlast_err, 1'b0);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_back_idle", bus.WREADY_M1, 1'b0);
        tick;
        // four-beat burst to S0 with a two-cycle slave stall
        aw(0, 3);
        tick;
        aw(-1, 0);
        for (int i = 0; i < 6; i++) begin
            bus.WREADY_S0 = rp[i][0];
            w(32'h1000 + 32'(bp[i]), 4'(bp[i] + 1), bp[i] == 3, 1'b1);
            @(negedge clk);
            check("t2_wready", bus.WREADY_M1, rp[i][0]);
            check("t2_wlast_s0", bus.WLAST_S0, bp[i] == 3);
            tick;
        end
        bus.WREADY_S0 = 1'b1;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_popped", bus.WREADY_M1, 1'b0);
        tick;
        // back-to-back S1 (len 1) then SDEFAULT (len 0)
        aw(1, 1);
        tick;
        aw(2, 0);
        @(negedge clk);
        check("t3_full_one", bus.aw_full, 1'b0);
        tick;
        aw(-1, 0);
        w(32'hA0, 4'h3, 1'b0, 1'b1);
        @(negedge clk);
        check("t3_full_two", bus.aw_full, 1'b1);
        check("t3_b0_s1", {bus.WVALID_S1, bus.WLAST_S1}, 2'b10);
        tick;
        w(32'hA1, 4'hC, 1'b1, 1'b1);
        @(negedge clk);
        check("t3_b1_s1", {bus.WVALID_S1, bus.WLAST_S1}, 2'b11);
        tick;
        w(32'hA2, 4'h1, 1'b1, 1'b1);
        @(negedge clk);
        check("t3_sd", {bus.WVALID_SDEFAULT, bus.WLAST_SDEFAULT, bus.WVALID_S1}, 3'b110);
        check("t3_sd_ready", bus.WREADY_M1, 1'b1);
        check("t3_full_clr", bus.aw_full, 1'b0);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        tick;
        // push in the same cycle as the last beat
        aw(0, 1);
        tick;
        aw(-1, 0);
        w(32'hB0, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_b0_s0", bus.WVALID_S0, 1'b1);
        tick;
        aw(1, 0);
        w(32'hB1, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_last_s0", bus.WLAST_S0, 1'b1);
        tick;
        aw(-1, 0);
        w(32'hB2, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_s1_nobubble", {bus.WVALID_S1, bus.WLAST_S1, bus.WREADY_M1}, 3'b111);
        check("t4_full", bus.aw_full, 1'b0);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        tick;
        // early WLAST from master
        aw(1, 1);
        tick;
        aw(-1, 0);
        w(32'hC0, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_err", bus.wlast_err, 1'b1);
        check("t5_wlast_b0", bus.WLAST_S1, 1'b0);
        tick;
        w(32'hC1, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_no_err", bus.wlast_err, 1'b0);
        check("t5_wlast_b1", bus.WLAST_S1, 1'b1);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        tick;
        // reset in the middle of a burst
        aw(0, 3);
        tick;
        aw(-1, 0);
        w(32'hD0, 4'hF, 1'b0, 1'b1);
        tick;
        w(32'hD1, 4'hF, 1'b0, 1'b1);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        w(32'hE0, 4'h5, 1'b0, 1'b1);
        @(negedge clk);
        check("t6_wvalid", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}, 3'b000);
        check("t6_wready", bus.WREADY_M1, 1'b0);
        check("t6_full", bus.aw_full, 1'b0);
        tick;
        aw(0, 1);
        @(negedge clk);
        check("t6_stall", bus.WREADY_M1, 1'b0);
        tick;
        aw(-1, 0);
        @(negedge clk);
        check("t6_b0", {bus.WREADY_M1, bus.WVALID_S0, bus.WLAST_S0, bus.wlast_err}, 4'b1100);
        tick;
        w(32'hE1, 4'hA, 1'b1, 1'b1);
        @(negedge clk);
        check("t6_b1", {bus.WVALID_S0, bus.WLAST_S0}, 2'b11);
        tick;
        w(32'h0, 4'h0, 1'b0, 1'b0);
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
